// File: rtl/expmul_pkg.sv
// Shared types and constants for the expmul job scheduler: FSM states,
// op codes, requester count and default operand/result widths.
package expmul_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_RES_W  = 30;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_EXP = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One-hot requester vector from a requester index.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic idx);
    return {idx, ~idx};
  endfunction

endpackage

// File: rtl/expmul_job_scheduler_rr_arbiter2.sv
// Combinational two-way round-robin arbiter: on a tie the requester that was
// not served last wins; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic [0:0] last,
  output logic [1:0] grant
);

  // Grant decode from the request vector and the last-served pointer.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last[0] ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/expmul_job_scheduler.sv
// Shares one iterative exponent/multiply engine between two requesters:
// round-robin arbitration, operand latching, start/done handshake with timeout.
module expmul_job_scheduler
  import expmul_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int TIMEOUT = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [DATA_W-1:0]   i_a0,
  input  logic [DATA_W-1:0]   i_b0,
  input  logic                i_op0,
  input  logic [DATA_W-1:0]   i_a1,
  input  logic [DATA_W-1:0]   i_b1,
  input  logic                i_op1,
  output logic [NUM_REQ-1:0]  o_gnt,
  output logic [NUM_REQ-1:0]  o_rsp_valid,
  output logic [RES_W-1:0]    o_rsp_data,
  output logic                o_rsp_err,
  output logic                o_eng_start,
  output logic [DATA_W-1:0]   o_eng_a,
  output logic [DATA_W-1:0]   o_eng_b,
  output logic                o_eng_op,
  output logic                o_eng_abort,
  input  logic                i_eng_done,
  input  logic [RES_W-1:0]    i_eng_result,
  output logic                o_busy
);

  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t               state_r;
  logic [0:0]           owner_r;
  logic [0:0]           last_r;
  logic [TIMER_W-1:0]   timer_r;

  logic [1:0]           grant_s;
  logic                 win_idx_s;
  logic [DATA_W-1:0]    win_a_s;
  logic [DATA_W-1:0]    win_b_s;
  logic                 win_op_s;

  rr_arbiter2 u_arb (
    .req   (i_req),
    .last  (last_r),
    .grant (grant_s)
  );

  // Operand mux for the arbitration winner.
  always_comb begin
    win_idx_s = 1'b0;
    win_a_s   = '0;
    win_b_s   = '0;
    win_op_s  = OP_MUL;
    if (grant_s[1]) begin
      win_idx_s = 1'b1;
      win_a_s   = i_a1;
      win_b_s   = i_b1;
      win_op_s  = i_op1;
    end else begin
      win_idx_s = 1'b0;
      win_a_s   = i_a0;
      win_b_s   = i_b0;
      win_op_s  = i_op0;
    end
  end

  // Job sequencing: capture the winner, pulse start, wait for done or timeout,
  // return the response and advance the round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;
      timer_r     <= '0;
      o_gnt       <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_eng_start <= 1'b0;
      o_eng_a     <= '0;
      o_eng_b     <= '0;
      o_eng_op    <= 1'b0;
      o_eng_abort <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_gnt       <= '0;
      o_eng_start <= 1'b0;
      o_rsp_valid <= '0;
      o_eng_abort <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|i_req) begin
            owner_r     <= win_idx_s;
            o_eng_a     <= win_a_s;
            o_eng_b     <= win_b_s;
            o_eng_op    <= win_op_s;
            o_gnt       <= grant_s;
            o_eng_start <= 1'b1;
            o_busy      <= 1'b1;
            state_r     <= ISSUE;
          end else begin
            o_busy      <= 1'b0;
          end
        end
        ISSUE: begin
          timer_r <= '0;
          state_r <= WAIT;
        end
        WAIT: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (i_eng_done) begin
            o_rsp_data  <= i_eng_result;
            o_rsp_err   <= 1'b0;
            o_rsp_valid <= idx_to_onehot(owner_r[0]);
            state_r     <= RESP;
          end else if (timer_r == TIMER_LAST) begin
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b1;
            o_eng_abort <= 1'b1;
            o_rsp_valid <= idx_to_onehot(owner_r[0]);
            state_r     <= RESP;
          end else begin
            timer_r     <= timer_r + TIMER_W'(1);
          end
        end
        RESP: begin
          last_r  <= owner_r;
          o_busy  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
